// File: rtl/avl_tg_pkg.sv
// Shared types and helpers for the Avalon traffic generator: FSM states, data pattern and
// burst-length clamp.
package avl_tg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StDrain,
        StDone
    } state_t;

    function automatic logic [31:0] pat(input logic [31:0] addr, input logic [7:0] pass_idx,
                                        input logic [31:0] seed);
        return addr ^ seed ^ {4{pass_idx}};
    endfunction

    function automatic logic [31:0] clamp_len(input logic [31:0] remaining,
                                              input logic [31:0] max_burst);
        return (remaining < max_burst) ? remaining : max_burst;
    endfunction

endpackage

// File: rtl/i_avl_bus.sv
// Avalon-style burst bus bundle: 32-bit address/data, byte enables, burst count up to 64 beats.
interface i_avl_bus;
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic        read;
    logic        write;
    logic [31:0] write_data;
    logic        begin_burst_transfer;
    logic [6:0]  burst_count;
    logic        request_ready;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        resp_ready;

    modport master (
        output address, byte_en, read, write, write_data, begin_burst_transfer, burst_count,
               resp_ready,
        input  request_ready, read_data, read_data_valid
    );

    modport slave (
        input  address, byte_en, read, write, write_data, begin_burst_transfer, burst_count,
               resp_ready,
        output request_ready, read_data, read_data_valid
    );
endinterface

// File: rtl/avl_tg_lfsr.sv
// 32-bit Galois LFSR (x^32 + x^22 + x^2 + x + 1) used to pace response back-pressure.
module avl_tg_lfsr #(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic clk,
    input  logic rest,
    input  logic advance,
    output logic out_bit
);
    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? 32'h8020_0003 : 32'h0000_0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign out_bit = state_q[0];
endmodule

// File: rtl/avl_bus_traffic_gen.sv
// Avalon burst master that writes a pass-dependent pattern over a window, reads it back under
// back-pressure and an in-flight limit, and checks every returned beat in order.
module avl_bus_traffic_gen
    import avl_tg_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int unsigned SPAN_LOG2    = 10,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned NUM_PASSES   = 1,
    parameter bit          BP_EN        = 1'b1,
    parameter logic [31:0] SEED         = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count,
    output logic [31:0] rd_beat_count,
    output logic [31:0] first_err_addr,
    i_avl_bus.master    avl_m
);
    localparam logic [31:0] WORDS  = 32'(2 ** (SPAN_LOG2 - 2));
    localparam logic [31:0] MAX_B  = 32'(MAX_BURST);
    localparam logic [31:0] MAX_IF = 32'(MAX_INFLIGHT);
    localparam logic [31:0] NPASS  = 32'(NUM_PASSES);

    state_t      state_q, state_d;
    logic [31:0] pass_q, pass_d;
    logic [31:0] base_q, base_d;     // word index of current burst start
    logic [31:0] beat_q, beat_d;     // beat index within current write burst
    logic [31:0] chk_q, chk_d;       // word index of next expected read beat
    logic [31:0] inflight_q, inflight_d;
    logic [15:0] err_q, err_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] first_q, first_d;

    logic [31:0] len, wr_addr, exp_addr, exp_data;
    logic        rd_cmd_ok, wr_acc, rd_acc, beat_acc, resp_rdy, lfsr_bit;

    logic [31:0] m_address, m_wdata;
    logic [3:0]  m_byte_en;
    logic [6:0]  m_count;
    logic        m_read, m_write, m_begin;

    avl_tg_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rest   (rest),
        .advance(1'b1),
        .out_bit(lfsr_bit)
    );

    assign len       = clamp_len(WORDS - base_q, MAX_B);
    assign wr_addr   = ADDR_BASE + ((base_q + beat_q) << 2);
    assign exp_addr  = ADDR_BASE + (chk_q << 2);
    assign exp_data  = pat(exp_addr, pass_q[7:0], SEED);
    assign rd_cmd_ok = (inflight_q + len) <= MAX_IF;
    assign resp_rdy  = (state_q inside {StWr, StRd, StDrain}) && (BP_EN ? lfsr_bit : 1'b1);
    assign wr_acc    = (state_q == StWr) && avl_m.request_ready;
    assign rd_acc    = (state_q == StRd) && rd_cmd_ok && avl_m.request_ready;
    // Beats arriving with nothing outstanding are stale and must not disturb the checker.
    assign beat_acc  = resp_rdy && avl_m.read_data_valid && (inflight_q != 32'd0);

    always_comb begin
        m_address = '0;
        m_wdata   = '0;
        m_byte_en = '0;
        m_count   = '0;
        m_read    = 1'b0;
        m_write   = 1'b0;
        m_begin   = 1'b0;
        case (state_q)
            StWr: begin
                m_write   = 1'b1;
                m_byte_en = 4'hF;
                m_address = wr_addr;
                m_wdata   = pat(wr_addr, pass_q[7:0], SEED);
                m_begin   = (beat_q == 32'd0);
                m_count   = len[6:0];
            end
            StRd: begin
                m_byte_en = 4'hF;
                if (rd_cmd_ok) begin
                    m_read    = 1'b1;
                    m_begin   = 1'b1;
                    m_address = ADDR_BASE + (base_q << 2);
                    m_count   = len[6:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        base_d     = base_q;
        beat_d     = beat_q;
        chk_d      = chk_q;
        err_d      = err_q;
        rd_cnt_d   = rd_cnt_q;
        first_d    = first_q;
        inflight_d = inflight_q + (rd_acc ? len : 32'd0) - (beat_acc ? 32'd1 : 32'd0);

        if (beat_acc) begin
            chk_d    = chk_q + 32'd1;
            rd_cnt_d = rd_cnt_q + 32'd1;
            if (avl_m.read_data != exp_data) begin
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                if (err_q == 16'd0) first_d = exp_addr;
            end
        end

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StWr;
                    pass_d   = '0;
                    base_d   = '0;
                    beat_d   = '0;
                    chk_d    = '0;
                    err_d    = '0;
                    rd_cnt_d = '0;
                    first_d  = '0;
                end
            end
            StWr: begin
                if (wr_acc) begin
                    if (beat_q + 32'd1 == len) begin
                        beat_d = '0;
                        if (base_q + len == WORDS) begin
                            base_d  = '0;
                            state_d = StRd;
                        end else begin
                            base_d = base_q + len;
                        end
                    end else begin
                        beat_d = beat_q + 32'd1;
                    end
                end
            end
            StRd: begin
                if (rd_acc) begin
                    if (base_q + len == WORDS) begin
                        base_d  = '0;
                        state_d = StDrain;
                    end else begin
                        base_d = base_q + len;
                    end
                end
            end
            StDrain: begin
                if (inflight_q == 32'd0) begin
                    if ((NPASS == 32'd0) || (pass_q + 32'd1 < NPASS)) begin
                        state_d = StWr;
                        pass_d  = pass_q + 32'd1;
                        chk_d   = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q    <= StIdle;
            pass_q     <= '0;
            base_q     <= '0;
            beat_q     <= '0;
            chk_q      <= '0;
            inflight_q <= '0;
            err_q      <= '0;
            rd_cnt_q   <= '0;
            first_q    <= '0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            base_q     <= base_d;
            beat_q     <= beat_d;
            chk_q      <= chk_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            rd_cnt_q   <= rd_cnt_d;
            first_q    <= first_d;
        end
    end

    assign avl_m.address              = m_address;
    assign avl_m.byte_en              = m_byte_en;
    assign avl_m.read                 = m_read;
    assign avl_m.write                = m_write;
    assign avl_m.write_data           = m_wdata;
    assign avl_m.begin_burst_transfer = m_begin;
    assign avl_m.burst_count          = m_count;
    assign avl_m.resp_ready           = resp_rdy;

    assign busy           = state_q inside {StWr, StRd, StDrain};
    assign done           = (state_q == StDone);
    assign err_count      = err_q;
    assign rd_beat_count  = rd_cnt_q;
    assign first_err_addr = first_q;
endmodule

// File: tb/tb_avl_bus_traffic_gen.sv
// Bench for avl_bus_traffic_gen: randomized memory slave with back-pressure, expected traffic
// derived from the burst/pattern rules, and directed runs for corruption, stalls and reset.
`timescale 1ns/1ps
module tb_avl_bus_traffic_gen;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam int SPAN = 5;
    localparam int W    = 8;
    localparam int MB   = 3;
    localparam int MI   = 4;
    localparam int NP   = 2;
    localparam int RD_BURSTS = (W + MB - 1) / MB;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] err_count;
    logic [31:0] rd_beat_count, first_err_addr;

    i_avl_bus bus ();

    avl_bus_traffic_gen #(
        .ADDR_BASE   (BASE),
        .SPAN_LOG2   (SPAN),
        .MAX_BURST   (MB),
        .MAX_INFLIGHT(MI),
        .NUM_PASSES  (NP),
        .BP_EN       (1'b1),
        .SEED        (SEED)
    ) dut (
        .clk           (clk),
        .rest          (rest),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .rd_beat_count (rd_beat_count),
        .first_err_addr(first_err_addr),
        .avl_m         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stimulus-owned knobs
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;
    int          rd_delay_min = 1;
    int          rd_delay_max = 4;
    bit          stall_run = 1'b0;

    // Reference state, owned by the monitor
    typedef struct { logic [31:0] addr; logic [31:0] data; logic bgn; logic [6:0] cnt; } wexp_t;
    typedef struct { logic [31:0] addr; logic [6:0] cnt; } rexp_t;
    typedef struct { logic [31:0] addr; int due; } rbeat_t;
    wexp_t       wq[$];
    rexp_t       rcq[$];
    rbeat_t      rq[$];
    logic [31:0] mem [W];
    int          outstanding = 0;
    int          m_err = 0, m_rd = 0;
    logic [31:0] m_first = '0;
    int          rd_cmds_seen = 0, wr_beats_seen = 0;
    int          stall_start = -100;
    int          cyc = 0;
    logic [31:0] m_lfsr;

    task automatic build_model();
        wq.delete();
        rcq.delete();
        rq.delete();
        outstanding   = 0;
        m_err         = 0;
        m_rd          = 0;
        m_first       = '0;
        rd_cmds_seen  = 0;
        wr_beats_seen = 0;
        for (int p = 0; p < NP; p++) begin
            for (int w = 0; w < W; w++) begin
                int          bstart = (w / MB) * MB;
                int          blen   = (W - bstart < MB) ? (W - bstart) : MB;
                logic [31:0] a      = BASE + 32'(4 * w);
                wq.push_back('{a, a ^ SEED ^ {4{8'(p)}}, (w % MB) == 0, 7'(blen)});
                if (p == 0 && (w % MB) == 0) rcq.push_back('{a, 7'(blen)});
            end
        end
        for (int p = 1; p < NP; p++) begin
            for (int w = 0; w < W; w += MB) begin
                rcq.push_back('{BASE + 32'(4 * w), 7'((W - w < MB) ? (W - w) : MB)});
            end
        end
    endtask

    always @(posedge clk) begin
        if (rest) m_lfsr <= SEED;
        else m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
    end

    // Slave driver: outputs change 1 time unit after the clock edge
    always @(posedge clk) begin
        cyc++;
        #1;
        bus.request_ready = !(stall_run && cyc > stall_start && cyc <= stall_start + 5) &&
                            ($urandom_range(3, 0) != 0);
        if (rq.size() != 0 && rq[0].due <= cyc) begin
            bus.read_data_valid = 1'b1;
            bus.read_data = mem[int'((rq[0].addr - BASE) >> 2) & (W - 1)] ^
                            {31'd0, corrupt_en && (rq[0].addr == corrupt_addr)};
        end else begin
            bus.read_data_valid = 1'b0;
            bus.read_data       = $urandom;
        end
    end

    // Monitor: values at the falling edge are what the next rising edge will act on
    logic        hold_prev = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic        prev_bgn;
    logic [6:0]  prev_cnt;
    always @(negedge clk) begin
        wexp_t we;
        rexp_t re;
        logic [31:0] ba;
        if (rest) begin
            hold_prev = 1'b0;
        end else begin
            if (start) build_model();
            check("busy_done_excl", 32'(busy & done), 32'd0);
            if (busy) check("resp_ready_lfsr", 32'(bus.resp_ready), 32'(m_lfsr[0]));
            else check("resp_ready_idle", 32'(bus.resp_ready), 32'd0);
            if (hold_prev) begin
                check("hold_write", 32'(bus.write), 32'd1);
                check("hold_addr", bus.address, prev_addr);
                check("hold_data", bus.write_data, prev_data);
                check("hold_begin", 32'(bus.begin_burst_transfer), 32'(prev_bgn));
                check("hold_count", 32'(bus.burst_count), 32'(prev_cnt));
            end
            hold_prev = bus.write && !bus.request_ready;
            prev_addr = bus.address;
            prev_data = bus.write_data;
            prev_bgn  = bus.begin_burst_transfer;
            prev_cnt  = bus.burst_count;

            if (bus.write && bus.request_ready) begin
                wr_beats_seen++;
                check("wr_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    we = wq.pop_front();
                    check("wr_addr", bus.address, we.addr);
                    check("wr_data", bus.write_data, we.data);
                    check("wr_begin", 32'(bus.begin_burst_transfer), 32'(we.bgn));
                    check("wr_byte_en", 32'(bus.byte_en), 32'hF);
                    if (we.bgn) check("wr_burst_count", 32'(bus.burst_count), 32'(we.cnt));
                end
                mem[int'((bus.address - BASE) >> 2) & (W - 1)] = bus.write_data;
                if (wr_beats_seen == 2) stall_start = cyc;
            end

            if (bus.read && bus.request_ready) begin
                check("rd_inflight_room", 32'(outstanding + int'(bus.burst_count) <= MI), 32'd1);
                check("rd_begin", 32'(bus.begin_burst_transfer), 32'd1);
                check("rd_expected", 32'(rcq.size() != 0), 32'd1);
                if (rcq.size() != 0) begin
                    re = rcq.pop_front();
                    check("rd_addr", bus.address, re.addr);
                    check("rd_burst_count", 32'(bus.burst_count), 32'(re.cnt));
                end
                for (int i = 0; i < int'(bus.burst_count); i++) begin
                    rq.push_back('{bus.address + 32'(4 * i),
                                   cyc + int'($urandom_range(rd_delay_max, rd_delay_min))});
                end
                outstanding += int'(bus.burst_count);
                rd_cmds_seen++;
            end

            if (bus.resp_ready && bus.read_data_valid && rq.size() != 0) begin
                ba = rq[0].addr;
                void'(rq.pop_front());
                outstanding--;
                m_rd++;
                if (corrupt_en && ba == corrupt_addr) begin
                    if (m_err == 0) m_first = ba;
                    m_err++;
                end
            end
            check("inflight_max", 32'(outstanding <= MI), 32'd1);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_write"}, 32'(bus.write), 32'd0);
        check({tag, "_read"}, 32'(bus.read), 32'd0);
        check({tag, "_resp_ready"}, 32'(bus.resp_ready), 32'd0);
        check({tag, "_byte_en"}, 32'(bus.byte_en), 32'd0);
        check({tag, "_address"}, bus.address, 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_rd_cnt"}, rd_beat_count, 32'd0);
        check({tag, "_first_err"}, first_err_addr, 32'd0);
    endtask

    initial begin
        int n;
        tick(3);
        rest = 1'b0;
        tick();
        check_idle_outputs("reset");
        check("reset_done", 32'(done), 32'd0);

        // Run 1: clean traffic with a 5-cycle request stall mid-burst
        stall_run = 1'b1;
        do_start();
        check("lat_write", 32'(bus.write), 32'd1);
        check("lat_addr", bus.address, BASE);
        check("lat_begin", 32'(bus.begin_burst_transfer), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        wait_done("run1_done", 3000);
        stall_run = 1'b0;
        check("run1_err", 32'(err_count), 32'(m_err));
        check("run1_rd_cnt", rd_beat_count, 32'(NP * W));
        check("run1_rd_model", rd_beat_count, 32'(m_rd));
        check("run1_first_err", first_err_addr, m_first);
        check("run1_wr_all_seen", 32'(wq.size()), 32'd0);
        check("run1_rd_all_seen", 32'(rcq.size()), 32'd0);
        check("run1_busy", 32'(busy), 32'd0);

        // Run 2: slave corrupts bit0 of the beat at BASE+8 in every pass
        corrupt_en   = 1'b1;
        corrupt_addr = BASE + 32'd8;
        do_start();
        check("run2_clr_err", 32'(err_count), 32'd0);
        check("run2_clr_rd", rd_beat_count, 32'd0);
        check("run2_clr_done", 32'(done), 32'd0);
        wait_done("run2_done", 3000);
        check("run2_err", 32'(err_count), 32'(NP));
        check("run2_err_model", 32'(err_count), 32'(m_err));
        check("run2_first_err", first_err_addr, BASE + 32'd8);
        check("run2_rd_cnt", rd_beat_count, 32'(m_rd));
        corrupt_en = 1'b0;

        // Run 3: slow returns, reset while draining the first pass
        rd_delay_min = 20;
        rd_delay_max = 20;
        do_start();
        n = 0;
        while (rd_cmds_seen < RD_BURSTS && n < 1000) begin
            tick();
            n++;
        end
        check("run3_reached_drain", 32'(rd_cmds_seen >= RD_BURSTS), 32'd1);
        check("run3_beats_pending", 32'(outstanding > 0), 32'd1);
        rest = 1'b1;
        tick();
        rest = 1'b0;
        check_idle_outputs("rst_drain");
        check("rst_drain_done", 32'(done), 32'd0);
        tick(40);
        check_idle_outputs("late_beats");
        rd_delay_min = 1;
        rd_delay_max = 4;

        // Run 4: full run after the abandoned one
        do_start();
        wait_done("run4_done", 3000);
        check("run4_err", 32'(err_count), 32'd0);
        check("run4_rd_cnt", rd_beat_count, 32'(NP * W));
        check("run4_first_err", first_err_addr, 32'd0);
        check("run4_wr_all_seen", 32'(wq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
